// File: rtl/pixel_window_scanner.sv
// Walks a greyscale frame in non-overlapping 2x2 windows. Each window is handed to an
// external averaging stage, and the average is written to a half-resolution destination RAM.
module pixel_window_scanner #(
  parameter int resolution = 8,
  parameter int SRC_W      = 56,
  parameter int SRC_H      = 56,
  parameter int SRC_ADDR_W = 12,
  parameter int DST_ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  src_rd_en,
  output logic [SRC_ADDR_W-1:0] src_addr,
  input  logic [resolution-1:0] src_data,
  output logic                  pixel_en,
  output logic [resolution-1:0] in1,
  output logic [resolution-1:0] in2,
  output logic [resolution-1:0] in3,
  output logic [resolution-1:0] in4,
  input  logic [resolution-1:0] avg_in,
  output logic                  dst_we,
  output logic [DST_ADDR_W-1:0] dst_addr,
  output logic [resolution-1:0] dst_data
);

  localparam int COLS = SRC_W / 2;
  localparam int C_W  = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [C_W-1:0]        C_LAST    = C_W'(COLS - 1);
  localparam logic [DST_ADDR_W-1:0] LAST_WIN  = DST_ADDR_W'(SRC_W * SRC_H / 4 - 1);
  localparam logic [SRC_ADDR_W-1:0] ROW_STEP  = SRC_ADDR_W'(SRC_W);
  localparam logic [SRC_ADDR_W-1:0] COL_STEP  = SRC_ADDR_W'(2);
  localparam logic [SRC_ADDR_W-1:0] WRAP_STEP = SRC_ADDR_W'(SRC_W + 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_EVAL,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [1:0]              k_q, k_d;
  logic [C_W-1:0]          c_q, c_d;
  logic [SRC_ADDR_W-1:0]   base_q, base_d;
  logic [DST_ADDR_W-1:0]   win_q, win_d;
  logic [SRC_ADDR_W-1:0]   src_addr_q, src_addr_d;
  logic [DST_ADDR_W-1:0]   dst_addr_q, dst_addr_d;
  logic [resolution-1:0]   dst_data_q, dst_data_d;
  logic [resolution-1:0]   pix_q [4];
  logic [resolution-1:0]   pix_d [4];

  // Tap k of the window whose top-left pixel is at base: tl, tr, bl, br.
  function automatic logic [SRC_ADDR_W-1:0] tap_addr(input logic [SRC_ADDR_W-1:0] base,
                                                     input logic [1:0]            k);
    case (k)
      2'd0:    tap_addr = base;
      2'd1:    tap_addr = base + SRC_ADDR_W'(1);
      2'd2:    tap_addr = base + ROW_STEP;
      default: tap_addr = base + ROW_STEP + SRC_ADDR_W'(1);
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d    = state_q;
    k_d        = k_q;
    c_d        = c_q;
    base_d     = base_q;
    win_d      = win_q;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    pix_d      = pix_q;
    busy       = 1'b0;
    done       = 1'b0;
    src_rd_en  = 1'b0;
    pixel_en   = 1'b0;
    dst_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          k_d        = 2'd0;
          c_d        = '0;
          base_d     = '0;
          win_d      = '0;
          src_addr_d = '0;
        end
      end
      S_FETCH: begin
        busy      = 1'b1;
        src_rd_en = 1'b1;
        // RAM data lags the strobe by one cycle, so tap k-1 lands while tap k is addressed.
        if (k_q != 2'd0) pix_d[k_q - 2'd1] = src_data;
        if (k_q == 2'd3) begin
          state_d = S_DRAIN;
        end else begin
          k_d        = k_q + 2'd1;
          src_addr_d = tap_addr(base_q, k_q + 2'd1);
        end
      end
      S_DRAIN: begin
        busy     = 1'b1;
        pix_d[3] = src_data;
        state_d  = S_EVAL;
      end
      S_EVAL: begin
        busy       = 1'b1;
        pixel_en   = 1'b1;
        dst_data_d = avg_in;
        dst_addr_d = win_q;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        busy   = 1'b1;
        dst_we = 1'b1;
        if (win_q == LAST_WIN) begin
          state_d = S_DONE;
        end else begin
          state_d = S_FETCH;
          k_d     = 2'd0;
          win_d   = win_q + DST_ADDR_W'(1);
          if (c_q == C_LAST) begin
            c_d    = '0;
            base_d = base_q + WRAP_STEP;
          end else begin
            c_d    = c_q + C_W'(1);
            base_d = base_q + COL_STEP;
          end
          src_addr_d = base_d;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      c_q        <= '0;
      base_q     <= '0;
      win_q      <= '0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      pix_q      <= '{default: '0};
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      c_q        <= c_d;
      base_q     <= base_d;
      win_q      <= win_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      pix_q      <= pix_d;
    end
  end

  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign in1      = pix_q[0];
  assign in2      = pix_q[1];
  assign in3      = pix_q[2];
  assign in4      = pix_q[3];

endmodule
